s2_demux_reg: RTL and testbench
===============================

// Module: s2_demux_reg
// PURPOSE
//   Registered 1-to-4 demultiplexer: the distribution-side counterpart of the S2 registered 4:1 mux cell.
//   A single input word is steered to one of four output lanes by the S2 select logic:
//   S1 = A1|B1, S0 = A0&B0, lane = {S1,S0}.
//   Each lane holds its word in a one-entry register with a valid/ready handshake.
//   Used in CA2 datapaths wherever the S2 mux fabric must be fed from one shared source.
// PARAMETERS
//   N      1  data width of din and of each lane output
//   DROP   0  0: backpressure when the target lane is full; 1: overwrite the full lane and count the overflow
//   CNT_W  4  width of the saturating overflow counter
// PORTS
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   clr        in   1      synchronous clear, active-high; priority over all other inputs
//   din        in   N      input word
//   in_valid   in   1      din is valid this cycle
//   in_ready   out  1      block accepts din this cycle
//   A1,B1      in   1      select high bit: S1 = A1|B1
//   A0,B0      in   1      select low bit: S0 = A0&B0
//   out0..out3 out  N      lane data registers (lane 0 = sel 2'b00 ... lane 3 = sel 2'b11)
//   out_valid  out  4      bit k = lane k holds an unconsumed word
//   out_ready  in   4      bit k = consumer takes lane k this cycle
//   ovf_cnt    out  CNT_W  overflow count; meaningful only when DROP=1, otherwise tied to 0
// BEHAVIOUR
//   Reset
//   - rst_n=0 asynchronously forces out0..out3=0, out_valid=4'b0000, ovf_cnt=0.
//   - clr=1 at a clock edge does the same synchronously. While clr=1, in_ready=0.
//   Select and acceptance
//   - sel={A1|B1, A0&B0} is combinational, sampled in the same cycle as din.
//   - accept = in_valid & in_ready.
//   - DROP=0: in_ready = !clr & (!out_valid[sel] | out_ready[sel]).
//   - DROP=1: in_ready = !clr.
//   Latency
//   - Accepted din appears on out[sel] with out_valid[sel]=1 at the next edge: 1 cycle.
//   - din is never combinationally visible on the outputs.
//   Per-lane register update at each edge, evaluated in priority order:
//   1. Write: accept & sel==k -> out_k <= din, out_valid[k] <= 1.
//   2. Drain: else if out_valid[k] & out_ready[k] -> out_valid[k] <= 0; out_k holds its value.
//   3. Otherwise hold.
//   - Write and drain of the same lane in the same cycle: the consumer takes the old word,
//     the new word loads, valid stays 1. There is no bubble, so throughput is 1 word/cycle per lane.
//   - Lanes other than sel are unaffected by a write and drain independently.
//   - out_ready on an empty lane is ignored.
//   - out_valid[k] never drops without a handshake, except on clr or rst_n.
//   Overflow (DROP=1 only)
//   - An accept into a lane with out_valid=1 and out_ready=0 overwrites the lane.
//   - ovf_cnt increments on each such accept and saturates at 2^CNT_W-1.
//   - ovf_cnt is cleared only by rst_n or clr.
//   Width rules
//   - All data paths are N bits, no extension or truncation.
//   - ovf_cnt saturates and never wraps.
//   Reset mid-operation
//   - Any word in flight is discarded; no partial handshakes survive.
//   - The first accept is possible in the cycle after clr deasserts.
// STRUCTURE
//   - Shared package s2_pkg holds:
//     - lane-select constants SEL_D0=2'b00, SEL_D1=2'b01, SEL_D2=2'b10, SEL_D3=2'b11;
//     - function s2_sel(A1,B1,A0,B0) returning {A1|B1, A0&B0}, reused by the S2 mux and this block.
//   - Sub-module s2_lane: one-entry holding register, instantiated 4 times.
//     - Inputs: clk, rst_n, clr, wr_en, wr_data, rd_ready.
//     - Outputs: data, valid, full_block (= valid & !rd_ready).
//   - Top level contains only: sel decode, in_ready, the write one-hot, and the ovf_cnt logic.
// TESTING
//   1. Reset: rst_n=0 mid-cycle with all lanes valid -> outputs 0 and out_valid=0000 immediately, before any clock edge.
//   2. Routing: N=8, DROP=0, out_ready=0; send 8'hA0..8'hA3 with (A1,B1,A0,B0) = 0000, 0011, 1000, 0111
//      -> out0=A0, out1=A1, out2=A2, out3=A3; out_valid=1111; each one cycle after its accept.
//   3. Backpressure: lane 2 full, out_ready=0, in_valid=1, sel=10 -> in_ready=0, out2 unchanged.
//      Then raise out_ready[2] -> in_ready=1 the same cycle, new word loads, out_valid[2] stays 1.
//   4. Streaming: sel=01, out_ready[1]=1, words 1..16 on consecutive cycles -> 16 accepts in 16 cycles,
//      out1 tracks din delayed 1 cycle.
//   5. Overflow: DROP=1, CNT_W=4, lane 0 full, out_ready=0; 20 accepts to sel=00
//      -> out0 = last word, ovf_cnt=15 (saturated). Then clr=1 -> ovf_cnt=0, out_valid=0000.
//   6. clr priority: clr=1 together with in_valid=1 and out_ready=1111 -> in_ready=0, no load,
//      all lanes cleared next edge.

Source files
------------

// File: rtl/s2_pkg.sv
// Shared S2 select definitions: lane constants and the {A1|B1, A0&B0} select function
// used by both the S2 mux and the S2 demux.
package s2_pkg;

  localparam logic [1:0] SEL_D0 = 2'b00;
  localparam logic [1:0] SEL_D1 = 2'b01;
  localparam logic [1:0] SEL_D2 = 2'b10;
  localparam logic [1:0] SEL_D3 = 2'b11;

  function automatic logic [1:0] s2_sel(input logic a1, input logic b1,
                                        input logic a0, input logic b0);
    return {a1 | b1, a0 & b0};
  endfunction

endpackage

// File: rtl/s2_lane.sv
// One-entry holding register with valid/ready drain; a write in the same cycle as a drain
// replaces the word without a bubble.
module s2_lane #(
  parameter int N = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         wr_en,
  input  logic [N-1:0] wr_data,
  input  logic         rd_ready,
  output logic [N-1:0] data,
  output logic         valid,
  output logic         full_block
);

  logic [N-1:0] r_data;
  logic         r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (clr) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (wr_en) begin
      r_data  <= wr_data;
      r_valid <= 1'b1;
    end else if (r_valid && rd_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign data       = r_data;
  assign valid      = r_valid;
  assign full_block = r_valid & ~rd_ready;

endmodule

// File: rtl/s2_demux_reg.sv
// Registered 1-to-4 demultiplexer steered by the S2 select logic; each lane is a
// one-entry register with its own handshake, optional overwrite-and-count on full lanes.
module s2_demux_reg
  import s2_pkg::*;
#(
  parameter int N     = 1,
  parameter int DROP  = 0,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [N-1:0]     din,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             A1,
  input  logic             B1,
  input  logic             A0,
  input  logic             B0,
  output logic [N-1:0]     out0,
  output logic [N-1:0]     out1,
  output logic [N-1:0]     out2,
  output logic [N-1:0]     out3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] ovf_cnt
);

  logic [1:0]   w_sel;
  logic         w_accept;
  logic [3:0]   w_wr_en;
  logic [3:0]   w_full_block;
  logic [N-1:0] w_data [4];

  assign w_sel    = s2_sel(A1, B1, A0, B0);
  assign w_accept = in_valid & in_ready;

  generate
    if (DROP != 0) begin : g_drop_ready
      assign in_ready = ~clr;
    end else begin : g_bp_ready
      assign in_ready = ~clr & ~w_full_block[w_sel];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_wr_en[gi] = w_accept & (w_sel == 2'(gi));

      s2_lane #(.N(N)) u_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .wr_en      (w_wr_en[gi]),
        .wr_data    (din),
        .rd_ready   (out_ready[gi]),
        .data       (w_data[gi]),
        .valid      (out_valid[gi]),
        .full_block (w_full_block[gi])
      );
    end
  endgenerate

  assign out0 = w_data[SEL_D0];
  assign out1 = w_data[SEL_D1];
  assign out2 = w_data[SEL_D2];
  assign out3 = w_data[SEL_D3];

  generate
    if (DROP != 0) begin : g_ovf
      localparam logic [CNT_W-1:0] OVF_MAX = '1;
      logic [CNT_W-1:0] r_ovf_cnt;

      // An overflow is an accept landing on a lane whose word is not being taken this cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_ovf_cnt <= '0;
        end else if (clr) begin
          r_ovf_cnt <= '0;
        end else if (w_accept && w_full_block[w_sel] && r_ovf_cnt != OVF_MAX) begin
          r_ovf_cnt <= r_ovf_cnt + 1'b1;
        end
      end

      assign ovf_cnt = r_ovf_cnt;
    end else begin : g_no_ovf
      assign ovf_cnt = '0;
    end
  endgenerate

endmodule

// File: tb/tb_s2_demux_reg.sv
// Bench for s2_demux_reg: a backpressure instance and an overwrite instance share one stimulus,
// checked every cycle against a lane-level model plus directed literal expectations.
module tb_s2_demux_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [7:0] din = '0;
  logic       in_valid = 1'b0;
  logic       A1 = 1'b0, B1 = 1'b0, A0 = 1'b0, B0 = 1'b0;
  logic [3:0] out_ready = '0;

  logic       iready [2];
  logic [7:0] dout   [2][4];
  logic [3:0] ovalid [2];
  logic [3:0] ovf    [2];

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt;

  always #5 clk = ~clk;

  s2_demux_reg #(.N(8), .DROP(0), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .in_valid(in_valid),
    .in_ready(iready[0]), .A1(A1), .B1(B1), .A0(A0), .B0(B0),
    .out0(dout[0][0]), .out1(dout[0][1]), .out2(dout[0][2]), .out3(dout[0][3]),
    .out_valid(ovalid[0]), .out_ready(out_ready), .ovf_cnt(ovf[0])
  );

  s2_demux_reg #(.N(8), .DROP(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .din(din), .in_valid(in_valid),
    .in_ready(iready[1]), .A1(A1), .B1(B1), .A0(A0), .B0(B0),
    .out0(dout[1][0]), .out1(dout[1][1]), .out2(dout[1][2]), .out3(dout[1][3]),
    .out_valid(ovalid[1]), .out_ready(out_ready), .ovf_cnt(ovf[1])
  );

  // ---------------- behavioural model ----------------
  logic [7:0] m_data  [2][4];
  logic [3:0] m_valid [2];
  int         m_ovf   [2];

  function automatic int cur_lane();
    int s1, s0;
    s1 = (A1 || B1) ? 1 : 0;
    s0 = (A0 && B0) ? 1 : 0;
    return 2 * s1 + s0;
  endfunction

  function automatic logic exp_ready(int d);
    int s;
    s = cur_lane();
    if (clr) return 1'b0;
    if (d == 1) return 1'b1;
    return !m_valid[d][s] || out_ready[s];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      for (int d = 0; d < 2; d++) begin
        m_valid[d] <= '0;
        m_ovf[d]   <= 0;
        for (int k = 0; k < 4; k++) m_data[d][k] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        logic acc;
        int   s;
        acc = in_valid && exp_ready(d);
        s   = cur_lane();
        for (int k = 0; k < 4; k++) begin
          if (acc && k == s) begin
            m_data[d][k]  <= din;
            m_valid[d][k] <= 1'b1;
          end else if (out_ready[k]) begin
            m_valid[d][k] <= 1'b0;
          end
        end
        if (acc && d == 1 && m_valid[d][s] && !out_ready[s] && m_ovf[d] < 15)
          m_ovf[d] <= m_ovf[d] + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        check($sformatf("cyc_in_ready[%0d]", d), 32'(iready[d]), 32'(exp_ready(d)));
        check($sformatf("cyc_out_valid[%0d]", d), 32'(ovalid[d]), 32'(m_valid[d]));
        check($sformatf("cyc_ovf_cnt[%0d]", d), 32'(ovf[d]), 32'(m_ovf[d]));
        for (int k = 0; k < 4; k++)
          check($sformatf("cyc_out%0d[%0d]", k, d), 32'(dout[d][k]), 32'(m_data[d][k]));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sel(input logic [3:0] code);
    {A1, B1, A0, B0} = code;
  endtask

  initial begin
    logic [3:0] codes [4];
    codes[0] = 4'b0000; codes[1] = 4'b0011; codes[2] = 4'b1000; codes[3] = 4'b0111;

    #3;
    check("reset_valid0", 32'(ovalid[0]), 32'h0);
    check("reset_ovf1", 32'(ovf[1]), 32'h0);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Routing: one word per lane, one-cycle latency.
    for (int i = 0; i < 4; i++) begin
      set_sel(codes[i]);
      din = 8'hA0 + 8'(i);
      in_valid = 1'b1;
      cyc();
      check($sformatf("route_lat%0d", i), 32'(dout[0][i]), 32'(8'hA0 + 8'(i)));
      $display("route: lane %0d <= %0h", i, dout[0][i]);
    end
    in_valid = 1'b0;
    check("route_out0", 32'(dout[0][0]), 32'h0A0);
    check("route_out1", 32'(dout[0][1]), 32'h0A1);
    check("route_out2", 32'(dout[0][2]), 32'h0A2);
    check("route_out3", 32'(dout[0][3]), 32'h0A3);
    check("route_valid", 32'(ovalid[0]), 32'hF);

    // Asynchronous reset mid-cycle with all lanes full.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_valid0", 32'(ovalid[0]), 32'h0);
    check("async_valid1", 32'(ovalid[1]), 32'h0);
    check("async_out3", 32'(dout[0][3]), 32'h0);
    $display("reset: out_valid=%b/%b", ovalid[0], ovalid[1]);
    cyc();
    rst_n = 1'b1;
    cyc();

    // Backpressure on lane 2, then release with simultaneous write.
    set_sel(4'b1000);
    din = 8'h55;
    in_valid = 1'b1;
    out_ready = 4'b0000;
    cyc();
    din = 8'h66;
    #1;
    check("bp_in_ready", 32'(iready[0]), 32'h0);
    cyc();
    check("bp_out2_held", 32'(dout[0][2]), 32'h55);
    out_ready = 4'b0100;
    #1;
    check("bp_release_ready", 32'(iready[0]), 32'h1);
    cyc();
    check("bp_out2_new", 32'(dout[0][2]), 32'h66);
    check("bp_valid2", 32'(ovalid[0][2]), 32'h1);
    $display("backpressure: out2=%0h valid=%b", dout[0][2], ovalid[0]);
    in_valid = 1'b0;
    out_ready = 4'b0000;
    cyc();

    // Streaming 16 words into lane 1 with the consumer always ready.
    set_sel(4'b0011);
    out_ready = 4'b0010;
    acc_cnt = 0;
    for (int i = 1; i <= 16; i++) begin
      din = 8'(i);
      in_valid = 1'b1;
      #1;
      if (in_valid && iready[0]) acc_cnt++;
      cyc();
      $display("stream: word %0d out1=%0d", i, dout[0][1]);
    end
    in_valid = 1'b0;
    check("stream_accepts", 32'(acc_cnt), 32'd16);
    check("stream_out1", 32'(dout[0][1]), 32'd16);
    out_ready = 4'b0000;
    cyc();

    // Overflow on lane 0 for the overwrite instance.
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    set_sel(4'b0000);
    din = 8'h10;
    in_valid = 1'b1;
    cyc();
    for (int i = 0; i < 20; i++) begin
      din = 8'h20 + 8'(i);
      cyc();
    end
    in_valid = 1'b0;
    check("ovf_out0", 32'(dout[1][0]), 32'h33);
    check("ovf_sat", 32'(ovf[1]), 32'd15);
    check("ovf_bp_out0", 32'(dout[0][0]), 32'h10);
    check("ovf_tied0", 32'(ovf[0]), 32'h0);
    $display("overflow: out0=%0h ovf_cnt=%0d", dout[1][0], ovf[1]);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("ovf_clr_cnt", 32'(ovf[1]), 32'h0);
    check("ovf_clr_valid", 32'(ovalid[1]), 32'h0);

    // clr priority over a concurrent accept and drain.
    set_sel(4'b0111);
    din = 8'h77;
    in_valid = 1'b1;
    cyc();
    check("clrp_pre_out3", 32'(dout[0][3]), 32'h77);
    clr = 1'b1;
    din = 8'h99;
    out_ready = 4'b1111;
    #1;
    check("clrp_ready0", 32'(iready[0]), 32'h0);
    check("clrp_ready1", 32'(iready[1]), 32'h0);
    cyc();
    check("clrp_valid0", 32'(ovalid[0]), 32'h0);
    check("clrp_valid1", 32'(ovalid[1]), 32'h0);
    check("clrp_out3", 32'(dout[1][3]), 32'h0);
    $display("clr priority: out_valid=%b/%b", ovalid[0], ovalid[1]);
    clr = 1'b0;
    in_valid = 1'b0;
    out_ready = 4'b0000;
    cyc();
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
